// File: rtl/coprosit_offload_queue.sv
// Commit-gated offload queue: holds issued X-interface instructions in a circular
// buffer and releases them to the coprosit pipeline in issue order once committed.
module coprosit_offload_queue #(
    parameter int DEPTH       = 4,
    parameter int ID_WIDTH    = 4,
    parameter int INSTR_WIDTH = 32,
    parameter int NUM_RS      = 2,
    parameter int RS_WIDTH    = 32,
    parameter int FORWARDING  = 1
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         issue_valid_i,
    output logic                         issue_ready_o,
    input  logic [ID_WIDTH-1:0]          issue_id_i,
    input  logic [INSTR_WIDTH-1:0]       issue_instr_i,
    input  logic [NUM_RS*RS_WIDTH-1:0]   issue_rs_i,
    input  logic                         commit_valid_i,
    input  logic [ID_WIDTH-1:0]          commit_id_i,
    input  logic                         commit_kill_i,
    output logic                         disp_valid_o,
    input  logic                         disp_ready_i,
    output logic [ID_WIDTH-1:0]          disp_id_o,
    output logic [INSTR_WIDTH-1:0]       disp_instr_o,
    output logic [NUM_RS*RS_WIDTH-1:0]   disp_rs_o,
    output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int RSW   = NUM_RS * RS_WIDTH;

    logic [DEPTH-1:0]       valid_q;
    logic [DEPTH-1:0]       committed_q;
    logic [DEPTH-1:0]       killed_q;
    logic [ID_WIDTH-1:0]    id_q    [DEPTH];
    logic [INSTR_WIDTH-1:0] instr_q [DEPTH];
    logic [RSW-1:0]         rs_q    [DEPTH];

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;

    logic             push;
    logic             pop;
    logic             head_live;
    logic             head_fwd;
    logic             eff_commit;
    logic             eff_kill;
    logic             new_hit;
    logic [DEPTH-1:0] commit_hit;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign issue_ready_o = (count < CNT_W'(DEPTH));
    assign push          = issue_valid_i && issue_ready_o;
    assign new_hit       = commit_valid_i && (commit_id_i == issue_id_i);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            commit_hit[i] = commit_valid_i && valid_q[i] && (id_q[i] == commit_id_i)
                            && !committed_q[i] && !killed_q[i];
        end
    end

    // A head whose flags are already set ignores further commit/kill, which keeps an offered head stable.
    assign head_live  = (count != '0);
    assign head_fwd   = (FORWARDING != 0) && head_live && commit_valid_i
                        && (commit_id_i == id_q[rd_ptr])
                        && !committed_q[rd_ptr] && !killed_q[rd_ptr];
    assign eff_commit = head_live && (committed_q[rd_ptr] || (head_fwd && !commit_kill_i));
    assign eff_kill   = head_live && (killed_q[rd_ptr] || (head_fwd && commit_kill_i));
    assign pop        = eff_kill || (eff_commit && disp_ready_i);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            valid_q     <= '0;
            committed_q <= '0;
            killed_q    <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (pop && (PTR_W'(i) == rd_ptr)) begin
                    valid_q[i]     <= 1'b0;
                    committed_q[i] <= 1'b0;
                    killed_q[i]    <= 1'b0;
                end else if (commit_hit[i]) begin
                    committed_q[i] <= !commit_kill_i;
                    killed_q[i]    <= commit_kill_i;
                end
                if (push && (PTR_W'(i) == wr_ptr)) begin
                    valid_q[i]     <= 1'b1;
                    committed_q[i] <= new_hit && !commit_kill_i;
                    killed_q[i]    <= new_hit && commit_kill_i;
                end
            end
            if (push) wr_ptr <= next_ptr(wr_ptr);
            if (pop)  rd_ptr <= next_ptr(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            id_q[wr_ptr]    <= issue_id_i;
            instr_q[wr_ptr] <= issue_instr_i;
            rs_q[wr_ptr]    <= issue_rs_i;
        end
    end

    assign disp_valid_o = eff_commit;
    assign disp_id_o    = eff_commit ? id_q[rd_ptr]    : '0;
    assign disp_instr_o = eff_commit ? instr_q[rd_ptr] : '0;
    assign disp_rs_o    = eff_commit ? rs_q[rd_ptr]    : '0;
    assign occupancy_o  = count;

endmodule

// File: tb/tb_coprosit_offload_queue.sv
// Directed scoreboard bench for coprosit_offload_queue: a forwarding DEPTH=4 instance
// plus a non-forwarding DEPTH=3 instance for the commit-timing comparison.
module tb_coprosit_offload_queue;

    typedef struct packed {
        logic [3:0]  id;
        logic [31:0] instr;
        logic [63:0] rs;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        issue_valid, issue_ready, commit_valid, commit_kill, disp_valid, disp_ready;
    logic [3:0]  issue_id, commit_id, disp_id;
    logic [31:0] issue_instr, disp_instr;
    logic [63:0] issue_rs, disp_rs;
    logic [2:0]  occupancy;

    logic        issue_valid_b, issue_ready_b, commit_valid_b, commit_kill_b, disp_valid_b, disp_ready_b;
    logic [3:0]  issue_id_b, commit_id_b, disp_id_b;
    logic [31:0] issue_instr_b, disp_instr_b;
    logic [63:0] issue_rs_b, disp_rs_b;
    logic [1:0]  occupancy_b;

    exp_t sb[$];
    int   n_compared   = 0;
    int   n_mismatched = 0;
    bit   mon_en       = 1'b0;

    always #5 clk = ~clk;

    coprosit_offload_queue #(.DEPTH(4), .FORWARDING(1)) dut (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid), .issue_ready_o(issue_ready), .issue_id_i(issue_id),
        .issue_instr_i(issue_instr), .issue_rs_i(issue_rs),
        .commit_valid_i(commit_valid), .commit_id_i(commit_id), .commit_kill_i(commit_kill),
        .disp_valid_o(disp_valid), .disp_ready_i(disp_ready), .disp_id_o(disp_id),
        .disp_instr_o(disp_instr), .disp_rs_o(disp_rs), .occupancy_o(occupancy)
    );

    coprosit_offload_queue #(.DEPTH(3), .FORWARDING(0)) dut_nofwd (
        .clk_i(clk), .rst_i(rst),
        .issue_valid_i(issue_valid_b), .issue_ready_o(issue_ready_b), .issue_id_i(issue_id_b),
        .issue_instr_i(issue_instr_b), .issue_rs_i(issue_rs_b),
        .commit_valid_i(commit_valid_b), .commit_id_i(commit_id_b), .commit_kill_i(commit_kill_b),
        .disp_valid_o(disp_valid_b), .disp_ready_i(disp_ready_b), .disp_id_o(disp_id_b),
        .disp_instr_o(disp_instr_b), .disp_rs_o(disp_rs_b), .occupancy_o(occupancy_b)
    );

    function automatic logic [63:0] make_rs(input logic [3:0] id);
        return {24'hB0_0000, 4'h0, id, 24'hC0_0000, 4'h0, id};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        n_compared++;
        assert (observed === expected) else begin
            n_mismatched++;
            $error("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction (optionally committing it in the same cycle), waiting a bounded time for ready.
    task automatic applyStimulus(input logic [3:0] id, input logic [31:0] instr,
                                 input bit expect_disp, input bit with_commit);
        int budget;
        budget       = 0;
        issue_valid  = 1'b1;
        issue_id     = id;
        issue_instr  = instr;
        issue_rs     = make_rs(id);
        while (!issue_ready && budget < 50) begin
            tick();
            budget++;
        end
        checkOutput("issue_accept", 64'(issue_ready), 64'd1);
        if (with_commit) begin
            commit_valid = 1'b1;
            commit_id    = id;
            commit_kill  = 1'b0;
        end
        if (expect_disp) sb.push_back('{id: id, instr: instr, rs: make_rs(id)});
        tick();
        issue_valid  = 1'b0;
        commit_valid = 1'b0;
    endtask

    task automatic commitOne(input logic [3:0] id, input bit kill);
        commit_valid = 1'b1;
        commit_id    = id;
        commit_kill  = kill;
        tick();
        commit_valid = 1'b0;
        commit_kill  = 1'b0;
    endtask

    task automatic waitEmpty(input string tag);
        int budget;
        budget = 0;
        while ((occupancy != 3'd0 || sb.size() != 0) && budget < 40) begin
            tick();
            budget++;
        end
        checkOutput({tag, "_drain_occ"}, 64'(occupancy), 64'd0);
        checkOutput({tag, "_drain_sb"}, 64'(sb.size()), 64'd0);
    endtask

    // Every accepted dispatch must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && disp_valid && disp_ready) begin
            checkOutput("disp_expected", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                checkOutput("disp_id", 64'(disp_id), 64'(e.id));
                checkOutput("disp_instr", 64'(disp_instr), 64'(e.instr));
                checkOutput("disp_rs", disp_rs, e.rs);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0; issue_id = '0; issue_instr = '0; issue_rs = '0;
        commit_valid = 1'b0; commit_id = '0; commit_kill = 1'b0; disp_ready = 1'b0;
        issue_valid_b = 1'b0; issue_id_b = '0; issue_instr_b = '0; issue_rs_b = '0;
        commit_valid_b = 1'b0; commit_id_b = '0; commit_kill_b = 1'b0; disp_ready_b = 1'b1;
        tick();
        tick();
        checkOutput("rst_disp_valid", 64'(disp_valid), 64'd0);
        checkOutput("rst_occupancy", 64'(occupancy), 64'd0);
        checkOutput("rst_issue_ready", 64'(issue_ready), 64'd1);
        checkOutput("rst_disp_id_zero", 64'(disp_id), 64'd0);
        rst = 1'b0;
        mon_en = 1'b1;
        disp_ready = 1'b1;

        // In-order dispatch of three committed instructions
        applyStimulus(4'd1, 32'hA1, 1'b1, 1'b0);
        applyStimulus(4'd2, 32'hA2, 1'b1, 1'b0);
        applyStimulus(4'd3, 32'hA3, 1'b1, 1'b0);
        checkOutput("t1_occ3", 64'(occupancy), 64'd3);
        commitOne(4'd1, 1'b0);
        commitOne(4'd2, 1'b0);
        commitOne(4'd3, 1'b0);
        waitEmpty("t1");

        // Fill to DEPTH, stall a fifth issue until the head pops
        for (int i = 0; i < 4; i++) applyStimulus(4'(i), 32'(32'hB0 + i), 1'b1, 1'b0);
        checkOutput("t2_full_ready", 64'(issue_ready), 64'd0);
        checkOutput("t2_full_occ", 64'(occupancy), 64'd4);
        issue_valid = 1'b1; issue_id = 4'd4; issue_instr = 32'hB4; issue_rs = make_rs(4'd4);
        tick();
        checkOutput("t2_stall_occ", 64'(occupancy), 64'd4);
        commit_valid = 1'b1; commit_id = 4'd0; commit_kill = 1'b0;
        tick();
        commit_valid = 1'b0;
        checkOutput("t2_no_pushthrough_occ", 64'(occupancy), 64'd3);
        applyStimulus(4'd4, 32'hB4, 1'b1, 1'b0);
        checkOutput("t2_refill_occ", 64'(occupancy), 64'd4);
        for (int i = 1; i < 5; i++) commitOne(4'(i), 1'b0);
        waitEmpty("t2");

        // Younger commit must not bypass an uncommitted head
        applyStimulus(4'd5, 32'hC5, 1'b1, 1'b0);
        applyStimulus(4'd6, 32'hC6, 1'b1, 1'b0);
        commitOne(4'd6, 1'b0);
        checkOutput("t3_no_bypass", 64'(disp_valid), 64'd0);
        tick();
        checkOutput("t3_still_blocked", 64'(disp_valid), 64'd0);
        checkOutput("t3_occ2", 64'(occupancy), 64'd2);
        commitOne(4'd5, 1'b0);
        waitEmpty("t3");

        // Killed entry dropped silently between two dispatches
        applyStimulus(4'd7, 32'hD7, 1'b1, 1'b0);
        applyStimulus(4'd8, 32'hD8, 1'b0, 1'b0);
        applyStimulus(4'd9, 32'hD9, 1'b1, 1'b0);
        commitOne(4'd8, 1'b1);
        commitOne(4'd7, 1'b0);
        checkOutput("t4_kill_no_pulse", 64'(disp_valid), 64'd0);
        checkOutput("t4_occ2", 64'(occupancy), 64'd2);
        commitOne(4'd9, 1'b0);
        waitEmpty("t4");

        // Forwarding vs stored-commit timing on an empty queue
        disp_ready = 1'b0;
        issue_valid = 1'b1; issue_id = 4'd2; issue_instr = 32'hE2; issue_rs = make_rs(4'd2);
        issue_valid_b = 1'b1; issue_id_b = 4'd2; issue_instr_b = 32'hE2; issue_rs_b = make_rs(4'd2);
        sb.push_back('{id: 4'd2, instr: 32'hE2, rs: make_rs(4'd2)});
        tick();
        issue_valid = 1'b0;
        issue_valid_b = 1'b0;
        commit_valid = 1'b1; commit_id = 4'd2; commit_kill = 1'b0;
        commit_valid_b = 1'b1; commit_id_b = 4'd2; commit_kill_b = 1'b0;
        #1;
        checkOutput("t5_fwd_valid_t1", 64'(disp_valid), 64'd1);
        checkOutput("t5_fwd_id_t1", 64'(disp_id), 64'd2);
        checkOutput("t5_nofwd_valid_t1", 64'(disp_valid_b), 64'd0);
        tick();
        commit_valid = 1'b0;
        commit_valid_b = 1'b0;
        #1;
        checkOutput("t5_nofwd_valid_t2", 64'(disp_valid_b), 64'd1);
        checkOutput("t5_nofwd_id_t2", 64'(disp_id_b), 64'd2);
        checkOutput("t5_fwd_held_t2", 64'(disp_valid), 64'd1);
        tick();
        checkOutput("t5_nofwd_drained", 64'(occupancy_b), 64'd0);
        disp_ready = 1'b1;
        waitEmpty("t5");

        // Stalled offer stays stable, ignores a late kill, and is discarded by reset
        disp_ready = 1'b0;
        applyStimulus(4'd4, 32'hF4, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            if (k == 1) begin
                commit_valid = 1'b1; commit_id = 4'd4; commit_kill = 1'b1;
            end
            #1;
            checkOutput("t6_stall_valid", 64'(disp_valid), 64'd1);
            checkOutput("t6_stall_id", 64'(disp_id), 64'd4);
            checkOutput("t6_stall_instr", 64'(disp_instr), 64'hF4);
            checkOutput("t6_stall_rs", disp_rs, make_rs(4'd4));
            tick();
            commit_valid = 1'b0;
            commit_kill = 1'b0;
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checkOutput("t6_rst_disp_valid", 64'(disp_valid), 64'd0);
        checkOutput("t6_rst_occ", 64'(occupancy), 64'd0);
        checkOutput("t6_rst_issue_ready", 64'(issue_ready), 64'd1);
        checkOutput("t6_rst_disp_id", 64'(disp_id), 64'd0);
        disp_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checkOutput("t6_post_rst_idle", 64'(disp_valid), 64'd0);
        end
        checkOutput("t6_sb_empty", 64'(sb.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
